hash_nonce_ctrl: RTL and testbench

HASH_NONCE_CTRL -- requirements
Module: hash_nonce_ctrl

---
 rtl/hash_nonce_ctrl.sv | 166 ++++++++++++++++
 tb/tb_hash_nonce_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_nonce_ctrl.sv
// ---------------------------------------------------------------------------
// hash_nonce_ctrl
//
// Purpose:
//   Drives a 36-round hash core through a nonce search. On an accepted start
//   the block content and difficulty target are latched. Each nonce is then
//   tried for 36 cycles (counter 0..35). At counter 35 the core's hash H is
//   compared against the target. A hit ends the search; a miss advances the
//   nonce. The search also ends on nonce exhaustion (a miss at 32'hFFFF_FFFF).
//
// Configuration:
//   HASH_CTRL_LIMIT_EN - when defined, a 16-bit attempt counter also ends the
//                        search after the MAX_TRIES-th miss.
//
// Parameters:
//   NONCE_START - first nonce tried after each start
//   MAX_TRIES   - attempt limit (only with HASH_CTRL_LIMIT_EN)
//
// Ports:
//   clk        in   clock, rising edge
//   reset_L    in   synchronous active-low reset
//   start      in   begin a search (honoured only in IDLE)
//   payload    in   96-bit block content, latched on accepted start
//   target     in   8-bit difficulty threshold, latched on accepted start
//   H          in   24-bit hash from the core
//   bloque_in  out  {payload_reg, nonce} driven to the core
//   counter    out  round counter driven to the core
//   fin        out  freezes core accumulation when 1
//   busy       out  high while searching
//   done       out  one-cycle pulse at search end
//   found      out  last search met the target
//   nonce_out  out  winning or last-tried nonce
//   hash_out   out  H captured at search end
// ---------------------------------------------------------------------------
module hash_nonce_ctrl #(
    parameter logic [31:0] NONCE_START = 32'h0000_0000,
    parameter logic [15:0] MAX_TRIES   = 16'd1000
) (
    input  logic         clk,
    input  logic         reset_L,
    input  logic         start,
    input  logic [95:0]  payload,
    input  logic [7:0]   target,
    input  logic [23:0]  H,
    output logic [127:0] bloque_in,
    output logic [5:0]   counter,
    output logic         fin,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [31:0]  nonce_out,
    output logic [23:0]  hash_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [95:0]  payload_reg;
    logic [7:0]   target_reg;
    logic [31:0]  nonce;
    logic         last_round;
    logic         hit;
    logic         exhausted;
    logic         limit_reached;
    logic         search_end;

    // The hash is only meaningful on the final round of an attempt.
    assign last_round = (state == RUN) && (counter == 6'd35);
    assign hit        = (H[23:16] < target_reg);
    assign exhausted  = (nonce == 32'hFFFF_FFFF);

`ifdef HASH_CTRL_LIMIT_EN
    logic [15:0] tries;

    // tries counts misses already completed, so this miss is number tries+1.
    assign limit_reached = ((tries + 16'd1) == MAX_TRIES);
`else
    logic unused_cfg;

    assign limit_reached = 1'b0;
    assign unused_cfg    = ^MAX_TRIES;
`endif

    assign search_end = last_round && (hit || exhausted || limit_reached);
    assign bloque_in  = {payload_reg, nonce};

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: DONE always falls back to IDLE after one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (search_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state alone.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
        fin  = (state != RUN);
    end

    // Datapath: latched inputs, nonce/round stepping and result capture.
    // The nonce is left untouched when the search ends so nonce_out reports
    // the attempt that finished it.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            payload_reg <= '0;
            target_reg  <= '0;
            nonce       <= '0;
            counter     <= '0;
            found       <= 1'b0;
            nonce_out   <= '0;
            hash_out    <= '0;
`ifdef HASH_CTRL_LIMIT_EN
            tries       <= '0;
`endif
        end else if (state == IDLE) begin
            counter <= '0;
            if (start) begin
                payload_reg <= payload;
                target_reg  <= target;
                nonce       <= NONCE_START;
                found       <= 1'b0;
`ifdef HASH_CTRL_LIMIT_EN
                tries       <= '0;
`endif
            end
        end else if (state == RUN) begin
            if (last_round) begin
                counter <= '0;
                if (search_end) begin
                    found     <= hit;
                    nonce_out <= nonce;
                    hash_out  <= H;
                end else begin
                    nonce <= nonce + 32'd1;
`ifdef HASH_CTRL_LIMIT_EN
                    tries <= tries + 16'd1;
`endif
                end
            end else begin
                counter <= counter + 6'd1;
            end
        end else begin
            counter <= '0;
        end
    end

endmodule

// File: tb/tb_hash_nonce_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hash_nonce_ctrl
//
// Purpose:
//   Self-checking bench for hash_nonce_ctrl. A behavioural hash core answers
//   each attempt either from a per-nonce script or from a mixing function.
//   Expected search outcomes come from a reference loop over nonces.
//   A second instance starts near the top of the nonce space to cover
//   wrap-around. A third instance covers the attempt limit, and exists only
//   when HASH_CTRL_LIMIT_EN is defined.
// ---------------------------------------------------------------------------
module tb_hash_nonce_ctrl;

    logic         clk = 1'b0;
    logic         reset_L;
    logic         start;
    logic [95:0]  payload;
    logic [7:0]   target;
    logic [23:0]  H;
    logic [127:0] bloque_in;
    logic [5:0]   counter;
    logic         fin, busy, done, found;
    logic [31:0]  nonce_out;
    logic [23:0]  hash_out;

    logic         w_start;
    logic [23:0]  w_H;
    logic [127:0] w_bloque_in;
    logic [5:0]   w_counter;
    logic         w_fin, w_busy, w_done, w_found;
    logic [31:0]  w_nonce_out;
    logic [23:0]  w_hash_out;

    int checks   = 0;
    int failures = 0;

    logic         h_mode;
    logic [23:0]  h_script [4];

    typedef struct packed {
        logic [95:0]      payload;
        logic [7:0]       target;
        logic [3:0][23:0] h;
        logic             exp_found;
        logic [31:0]      exp_nonce;
        logic [23:0]      exp_hash;
        logic [15:0]      exp_edges;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    hash_nonce_ctrl dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .start     (start),
        .payload   (payload),
        .target    (target),
        .H         (H),
        .bloque_in (bloque_in),
        .counter   (counter),
        .fin       (fin),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .nonce_out (nonce_out),
        .hash_out  (hash_out)
    );

    hash_nonce_ctrl #(.NONCE_START(32'hFFFF_FFFE), .MAX_TRIES(16'd4)) dut_wrap (
        .clk       (clk),
        .reset_L   (reset_L),
        .start     (w_start),
        .payload   (payload),
        .target    (8'h00),
        .H         (w_H),
        .bloque_in (w_bloque_in),
        .counter   (w_counter),
        .fin       (w_fin),
        .busy      (w_busy),
        .done      (w_done),
        .found     (w_found),
        .nonce_out (w_nonce_out),
        .hash_out  (w_hash_out)
    );

`ifdef HASH_CTRL_LIMIT_EN
    logic         l_start;
    logic [23:0]  l_H;
    logic [127:0] l_bloque_in;
    logic [5:0]   l_counter;
    logic         l_fin, l_busy, l_done, l_found;
    logic [31:0]  l_nonce_out;
    logic [23:0]  l_hash_out;

    hash_nonce_ctrl #(.NONCE_START(32'h0), .MAX_TRIES(16'd4)) dut_lim (
        .clk       (clk),
        .reset_L   (reset_L),
        .start     (l_start),
        .payload   (payload),
        .target    (8'h00),
        .H         (l_H),
        .bloque_in (l_bloque_in),
        .counter   (l_counter),
        .fin       (l_fin),
        .busy      (l_busy),
        .done      (l_done),
        .found     (l_found),
        .nonce_out (l_nonce_out),
        .hash_out  (l_hash_out)
    );

    always_comb l_H = (l_counter >= 6'd34) ? 24'h777777 : 24'h000000;
`endif

    // Arbitrary mixing function standing in for the real hash.
    function automatic logic [23:0] hash_of(input logic [95:0] p, input logic [31:0] n);
        logic [31:0] x;
        x = p[31:0] ^ p[63:32] ^ p[95:64] ^ (n * 32'h9E37_79B1);
        x = x ^ (x >> 15);
        x = x * 32'h2C1B_3C6D;
        x = x ^ (x >> 12);
        return x[31:8];
    endfunction

    // Hash core model. Before round 34 it returns zero, which would pass any
    // nonzero target, so evaluating too early shows up as a false hit.
    always_comb begin
        H = 24'h000000;
        if (counter >= 6'd34) begin
            if (h_mode) begin
                H = (bloque_in[31:0] < 32'd4) ? h_script[bloque_in[1:0]] : 24'hFFFFFF;
            end else begin
                H = hash_of(bloque_in[127:32], bloque_in[31:0]);
            end
        end
    end

    always_comb w_H = (w_counter >= 6'd34) ? 24'hABCDEF : 24'h000000;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Starts one search on the main instance and follows it to its done pulse.
    task automatic applyStimulus(input logic [95:0] p, input logic [7:0] t, input logic ef,
                                 input logic [31:0] en, input logic [23:0] eh,
                                 input int ee, input string name);
        int          edges;
        logic        ok_fin, ok_cnt, ok_pay, ok_seq;
        logic [31:0] seen [$];
        payload = p;
        target  = t;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        checkOutput({name, "_busy_after_start"}, busy, 1'b1);
        checkOutput({name, "_found_cleared"}, found, 1'b0);
        edges  = 0;
        ok_fin = 1'b1;
        ok_cnt = 1'b1;
        ok_pay = 1'b1;
        while (!done && edges < ee + 40) begin
            if (busy) begin
                if (counter == 6'd0) seen.push_back(bloque_in[31:0]);
                if (fin) ok_fin = 1'b0;
                if (counter > 6'd35) ok_cnt = 1'b0;
                if (bloque_in[127:32] != p) ok_pay = 1'b0;
            end
            tick();
            edges++;
        end
        checkOutput({name, "_done"}, done, 1'b1);
        checkOutput({name, "_latency"}, edges, ee);
        checkOutput({name, "_found"}, found, ef);
        checkOutput({name, "_nonce_out"}, nonce_out, en);
        checkOutput({name, "_hash_out"}, hash_out, eh);
        checkOutput({name, "_done_state"}, {busy, fin, counter}, {1'b0, 1'b1, 6'd0});
        checkOutput({name, "_fin_low_in_run"}, ok_fin, 1'b1);
        checkOutput({name, "_counter_range"}, ok_cnt, 1'b1);
        checkOutput({name, "_payload_held"}, ok_pay, 1'b1);
        ok_seq = (seen.size() == ee / 36);
        foreach (seen[k]) if (seen[k] != 32'(k)) ok_seq = 1'b0;
        checkOutput({name, "_nonce_steps"}, ok_seq, 1'b1);
        tick();
        checkOutput({name, "_done_one_cycle"}, {done, busy, fin}, {1'b0, 1'b0, 1'b1});
        checkOutput({name, "_results_held"}, {found, nonce_out, hash_out}, {ef, en, eh});
    endtask

    initial begin
        int          edges;
        logic        saw_done;
        logic [95:0] rp;
        logic [7:0]  rt;
        int          attempts;
        logic [31:0] seen_w [$];

        reset_L = 1'b0;
        start   = 1'b1;
        w_start = 1'b0;
`ifdef HASH_CTRL_LIMIT_EN
        l_start = 1'b0;
`endif
        payload = 96'hDEAD_BEEF_0000_1111_2222_3333;
        target  = 8'hFF;
        h_mode  = 1'b1;
        foreach (h_script[k]) h_script[k] = 24'hFFFFFF;

        // Directed vectors: scripted hash per nonce, expected outcome.
        vecs[0] = '{payload: 96'h0123_4567_89AB_CDEF_0123_45AB, target: 8'hFF,
                    h: {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h100000},
                    exp_found: 1'b1, exp_nonce: 32'd0, exp_hash: 24'h100000, exp_edges: 16'd36};
        vecs[1] = '{payload: 96'h0123_4567_89AB_CDEF_0123_45AB, target: 8'h06,
                    h: {24'hFFFFFF, 24'h050000, 24'hF00000, 24'hF00000},
                    exp_found: 1'b1, exp_nonce: 32'd2, exp_hash: 24'h050000, exp_edges: 16'd108};
        vecs[2] = '{payload: 96'hAAAA_5555_AAAA_5555_AAAA_5555, target: 8'h10,
                    h: {24'hFFFFFF, 24'hFFFFFF, 24'h0FFFFF, 24'h100000},
                    exp_found: 1'b1, exp_nonce: 32'd1, exp_hash: 24'h0FFFFF, exp_edges: 16'd72};
        vecs[3] = '{payload: 96'h0000_0000_0000_0000_0000_0001, target: 8'h01,
                    h: {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h00FFFF},
                    exp_found: 1'b1, exp_nonce: 32'd0, exp_hash: 24'h00FFFF, exp_edges: 16'd36};
        vecs[4] = '{payload: 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, target: 8'hFF,
                    h: {24'hFFFFFF, 24'h000001, 24'hFE1234, 24'hFF0000},
                    exp_found: 1'b1, exp_nonce: 32'd1, exp_hash: 24'hFE1234, exp_edges: 16'd72};

        // Reset held with start high.
        repeat (3) tick();
        checkOutput("reset_status", {busy, done, found, fin}, {1'b0, 1'b0, 1'b0, 1'b1});
        checkOutput("reset_counter", counter, 6'd0);
        checkOutput("reset_bloque_in", bloque_in, 128'd0);
        checkOutput("reset_results", {nonce_out, hash_out}, 56'd0);
        start   = 1'b0;
        reset_L = 1'b1;
        tick();
        checkOutput("idle_after_reset", {busy, done, fin}, {1'b0, 1'b0, 1'b1});

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 4; k++) h_script[k] = vecs[i].h[k];
            applyStimulus(vecs[i].payload, vecs[i].target, vecs[i].exp_found,
                          vecs[i].exp_nonce, vecs[i].exp_hash, int'(vecs[i].exp_edges),
                          $sformatf("vec%0d", i));
        end

        // Start during RUN and during DONE must be ignored.
        h_script[0] = 24'h100000;
        payload = 96'h1111_2222_3333_4444_5555_6666;
        target  = 8'hFF;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        repeat (10) tick();
        payload = 96'h9999_8888_7777_6666_5555_4444;
        target  = 8'h00;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        edges   = 11;
        while (!done && edges < 80) begin
            tick();
            edges++;
        end
        checkOutput("ign_run_latency", edges, 36);
        checkOutput("ign_run_found", found, 1'b1);
        checkOutput("ign_run_payload", bloque_in[127:32], 96'h1111_2222_3333_4444_5555_6666);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("ign_done_idle", {busy, done}, 2'b00);
        tick();
        checkOutput("ign_done_still_idle", {busy, done}, 2'b00);

        // Reset in the middle of an attempt.
        foreach (h_script[k]) h_script[k] = 24'hFFFFFF;
        payload = 96'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;
        target  = 8'h80;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        edges   = 0;
        while (counter != 6'd20 && edges < 60) begin
            tick();
            edges++;
        end
        checkOutput("midrst_reached_20", counter, 6'd20);
        reset_L = 1'b0;
        tick();
        checkOutput("midrst_state", {busy, done, fin, found}, {1'b0, 1'b0, 1'b1, 1'b0});
        checkOutput("midrst_counter", counter, 6'd0);
        checkOutput("midrst_bloque_in", bloque_in, 128'd0);
        reset_L  = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        checkOutput("midrst_no_done", saw_done, 1'b0);
        h_script[0] = 24'h100000;
        applyStimulus(96'h0123_4567_89AB_CDEF_0123_45AB, 8'hFF, 1'b1, 32'd0, 24'h100000, 36, "post_reset");

        // Randomized searches against the reference nonce loop.
        h_mode = 1'b0;
        for (int r = 0; r < 6; r++) begin
            do begin
                rp = {$urandom, $urandom, $urandom};
                rt = 8'($urandom_range(40, 255));
                attempts = 0;
                while (attempts < 16 && !(hash_of(rp, 32'(attempts))[23:16] < rt)) attempts++;
            end while (attempts >= 16);
            applyStimulus(rp, rt, 1'b1, 32'(attempts), hash_of(rp, 32'(attempts)),
                          36 * (attempts + 1), $sformatf("rand%0d", r));
        end

        // Nonce exhaustion: two attempts from FFFF_FFFE, target zero.
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        edges   = 0;
        while (!w_done && edges < 200) begin
            if (w_busy && w_counter == 6'd0) seen_w.push_back(w_bloque_in[31:0]);
            tick();
            edges++;
        end
        checkOutput("wrap_latency", edges, 72);
        checkOutput("wrap_found", w_found, 1'b0);
        checkOutput("wrap_nonce_out", w_nonce_out, 32'hFFFF_FFFF);
        checkOutput("wrap_hash_out", w_hash_out, 24'hABCDEF);
        checkOutput("wrap_attempts", seen_w.size(), 2);
        if (seen_w.size() == 2) checkOutput("wrap_nonces", {seen_w[0], seen_w[1]}, {32'hFFFF_FFFE, 32'hFFFF_FFFF});
        tick();
        checkOutput("wrap_idle", {w_busy, w_done}, 2'b00);

`ifdef HASH_CTRL_LIMIT_EN
        // Attempt limit of four with an unreachable target.
        l_start = 1'b1;
        tick();
        l_start = 1'b0;
        edges   = 0;
        while (!l_done && edges < 300) begin
            tick();
            edges++;
        end
        checkOutput("limit_latency", edges, 144);
        checkOutput("limit_found", l_found, 1'b0);
        checkOutput("limit_nonce_out", l_nonce_out, 32'd3);
        checkOutput("limit_hash_out", l_hash_out, 24'h777777);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
